// File: rtl/perf_counter_unit_if.sv
// Datapath-side handshake for the performance counter unit: per-cycle
// retirement/stall events flow in, the pipeline enable flows back out.
interface perf_counter_unit_if;
  logic stall;
  logic retire;
  logic retire_arith;
  logic retire_mem;
  logic finish;
  logic advance;

  // Datapath drives events and consumes the pipeline enable.
  modport master (
    output stall, retire, retire_arith, retire_mem, finish,
    input  advance
  );

  // Counter unit consumes events and produces the pipeline enable.
  modport slave (
    input  stall, retire, retire_arith, retire_mem, finish,
    output advance
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Performance counter unit: run/single-step control FSM that gates the
// datapath pipeline, plus five saturating 32-bit event counters with a
// sticky overflow flag. A DONE state freezes everything until reset.
module perf_counter_unit (
  input  logic                clkFPGA,
  input  logic                rst,
  input  logic                stepping_flag,
  input  logic                next_instr,
  input  logic                clear,
  perf_counter_unit_if.slave  dp,
  output logic [31:0]         stall_count,
  output logic [31:0]         arith_count,
  output logic [31:0]         mem_count,
  output logic [31:0]         cycles,
  output logic [31:0]         instr_count,
  output logic                overflow,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_IDLE = 2'd1,
    STEP_ADV  = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t      state_r;
  state_t      state_next_s;
  logic        sync1_r;
  logic        sync2_r;
  logic        sync3_r;
  logic        step_rise_s;
  logic        advance_s;
  logic [31:0] cycles_r;
  logic [31:0] stall_r;
  logic [31:0] instr_r;
  logic [31:0] arith_r;
  logic [31:0] mem_r;
  logic        overflow_r;
  logic        inc_stall_s;
  logic        inc_instr_s;
  logic        inc_arith_s;
  logic        inc_mem_s;
  logic        sat_hit_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    if (en && (value != CNT_MAX)) begin
      return value + 32'd1;
    end else begin
      return value;
    end
  endfunction

  // True when an increment is attempted on an already saturated counter.
  function automatic logic sat_try(input logic [31:0] value, input logic en);
    return en && (value == CNT_MAX);
  endfunction

  // Button synchronizer (two flops) plus a third flop for rising-edge detect.
  always_ff @(posedge clkFPGA) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= next_instr;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign step_rise_s = sync2_r & ~sync3_r;

  // FSM state register; the reset target follows the stepping mode.
  always_ff @(posedge clkFPGA) begin
    if (!rst) begin
      state_r <= stepping_flag ? STEP_IDLE : RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; finish only matters while the pipeline advances.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (dp.finish) begin
          state_next_s = DONE;
        end else if (stepping_flag) begin
          state_next_s = STEP_IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      STEP_IDLE: begin
        if (step_rise_s) begin
          state_next_s = STEP_ADV;
        end else if (!stepping_flag) begin
          state_next_s = RUN;
        end else begin
          state_next_s = STEP_IDLE;
        end
      end
      STEP_ADV: begin
        if (dp.finish) begin
          state_next_s = DONE;
        end else begin
          state_next_s = STEP_IDLE;
        end
      end
      DONE: begin
        state_next_s = DONE;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // FSM outputs: pipeline enabled in RUN and STEP_ADV, never while in reset.
  always_comb begin
    advance_s = 1'b0;
    case (state_r)
      RUN:      advance_s = rst;
      STEP_ADV: advance_s = rst;
      default:  advance_s = 1'b0;
    endcase
  end

  assign inc_stall_s = advance_s & dp.stall;
  assign inc_instr_s = advance_s & dp.retire;
  assign inc_arith_s = advance_s & dp.retire & dp.retire_arith & ~dp.retire_mem;
  assign inc_mem_s   = advance_s & dp.retire & dp.retire_mem;
  assign sat_hit_s   = sat_try(cycles_r, advance_s) | sat_try(stall_r, inc_stall_s) |
                       sat_try(instr_r, inc_instr_s) | sat_try(arith_r, inc_arith_s) |
                       sat_try(mem_r, inc_mem_s);

  // Event counters and sticky overflow; clear beats any same-cycle increment.
  always_ff @(posedge clkFPGA) begin
    if (!rst) begin
      cycles_r   <= 32'd0;
      stall_r    <= 32'd0;
      instr_r    <= 32'd0;
      arith_r    <= 32'd0;
      mem_r      <= 32'd0;
      overflow_r <= 1'b0;
    end else if (clear) begin
      cycles_r   <= 32'd0;
      stall_r    <= 32'd0;
      instr_r    <= 32'd0;
      arith_r    <= 32'd0;
      mem_r      <= 32'd0;
      overflow_r <= 1'b0;
    end else begin
      cycles_r   <= sat_inc(cycles_r, advance_s);
      stall_r    <= sat_inc(stall_r, inc_stall_s);
      instr_r    <= sat_inc(instr_r, inc_instr_s);
      arith_r    <= sat_inc(arith_r, inc_arith_s);
      mem_r      <= sat_inc(mem_r, inc_mem_s);
      overflow_r <= overflow_r | sat_hit_s;
    end
  end

  assign dp.advance  = advance_s;
  assign cycles      = cycles_r;
  assign stall_count = stall_r;
  assign instr_count = instr_r;
  assign arith_count = arith_r;
  assign mem_count   = mem_r;
  assign overflow    = overflow_r;
  assign state       = state_r;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: directed scenarios plus a
// randomized phase, all compared against a behavioural model.
module tb_perf_counter_unit;

  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  logic        clkFPGA;
  logic        rst;
  logic        stepping_flag;
  logic        next_instr;
  logic        clear;
  logic [31:0] stall_count;
  logic [31:0] arith_count;
  logic [31:0] mem_count;
  logic [31:0] cycles;
  logic [31:0] instr_count;
  logic        overflow;
  logic [1:0]  state;

  perf_counter_unit_if dp_if ();

  perf_counter_unit dut (
    .clkFPGA       (clkFPGA),
    .rst           (rst),
    .stepping_flag (stepping_flag),
    .next_instr    (next_instr),
    .clear         (clear),
    .dp            (dp_if.slave),
    .stall_count   (stall_count),
    .arith_count   (arith_count),
    .mem_count     (mem_count),
    .cycles        (cycles),
    .instr_count   (instr_count),
    .overflow      (overflow),
    .state         (state)
  );

  initial clkFPGA = 1'b0;
  always #5 clkFPGA = ~clkFPGA;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (mode: 0 run, 1 waiting for step, 2 stepping, 3 done)
  longint m_cycles, m_stall, m_instr, m_arith, m_mem;
  bit     m_ovf;
  int     m_mode;
  bit [2:0] m_btn;   // bit0 = newest button sample

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint bump(input longint v, input bit en);
    if (!en) return v;
    if (v >= CMAX) begin
      m_ovf = 1'b1;
      return v;
    end
    return v + 1;
  endfunction

  task automatic model_zero();
    m_cycles = 0; m_stall = 0; m_instr = 0; m_arith = 0; m_mem = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit moving, pressed;
    if (!rst) begin
      model_zero();
      m_btn  = 3'b000;
      m_mode = stepping_flag ? 1 : 0;
      return;
    end
    moving  = (m_mode == 0) || (m_mode == 2);
    pressed = m_btn[1] && !m_btn[2];
    if (clear) begin
      model_zero();
    end else if (moving) begin
      m_cycles = bump(m_cycles, 1'b1);
      m_stall  = bump(m_stall, dp_if.stall);
      m_instr  = bump(m_instr, dp_if.retire);
      m_arith  = bump(m_arith, dp_if.retire && dp_if.retire_arith && !dp_if.retire_mem);
      m_mem    = bump(m_mem, dp_if.retire && dp_if.retire_mem);
    end
    if (moving && dp_if.finish) m_mode = 3;
    else if (m_mode == 0 && stepping_flag) m_mode = 1;
    else if (m_mode == 1 && pressed) m_mode = 2;
    else if (m_mode == 1 && !stepping_flag) m_mode = 0;
    else if (m_mode == 2) m_mode = 1;
    m_btn = {m_btn[1:0], next_instr};
  endtask

  task automatic check_all();
    check_eq("cycles", cycles, 32'(m_cycles));
    check_eq("stall_count", stall_count, 32'(m_stall));
    check_eq("instr_count", instr_count, 32'(m_instr));
    check_eq("arith_count", arith_count, 32'(m_arith));
    check_eq("mem_count", mem_count, 32'(m_mem));
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_eq("state", {30'd0, state}, 32'(m_mode));
    check_eq("advance", {31'd0, dp_if.advance},
             {31'd0, rst && (m_mode == 0 || m_mode == 2)});
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clkFPGA);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_events();
    dp_if.stall = 1'b0; dp_if.retire = 1'b0; dp_if.retire_arith = 1'b0;
    dp_if.retire_mem = 1'b0; dp_if.finish = 1'b0;
  endtask

  int kind [10];
  bit stl  [10];
  int adv_n, adv_first;

  initial begin
    m_mode = 0; m_btn = 3'b000; model_zero();
    rst = 1'b0; stepping_flag = 1'b0; next_instr = 1'b0; clear = 1'b0;
    idle_events();

    // Reset into RUN
    tick(); tick();
    check_eq("rst_state", {30'd0, state}, 32'd0);
    check_eq("rst_advance", {31'd0, dp_if.advance}, 32'd0);
    check_eq("rst_cycles", cycles, 32'd0);

    // Free-run: 10 cycles, 3 stalls, 6 retires (4 arith, 2 mem)
    rst  = 1'b1;
    kind = '{1, 2, 0, 1, 0, 1, 2, 0, 1, 0};
    stl  = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      dp_if.stall        = stl[i];
      dp_if.retire       = (kind[i] != 0);
      dp_if.retire_arith = (kind[i] == 1);
      dp_if.retire_mem   = (kind[i] == 2);
      tick();
    end
    idle_events();
    check_eq("fr_cycles", cycles, 32'd10);
    check_eq("fr_stall", stall_count, 32'd3);
    check_eq("fr_instr", instr_count, 32'd6);
    check_eq("fr_arith", arith_count, 32'd4);
    check_eq("fr_mem", mem_count, 32'd2);

    // Class conflict: mem wins, arith untouched
    clear = 1'b1; tick(); clear = 1'b0;
    dp_if.retire = 1'b1; dp_if.retire_arith = 1'b1; dp_if.retire_mem = 1'b1;
    tick();
    check_eq("cc_mem", mem_count, 32'd1);
    check_eq("cc_arith", arith_count, 32'd0);
    check_eq("cc_instr", instr_count, 32'd1);
    // Class bits without retire do not count
    dp_if.retire = 1'b0;
    tick();
    check_eq("nr_mem", mem_count, 32'd1);
    check_eq("nr_arith", arith_count, 32'd0);

    // Clear beats same-cycle retire; state untouched
    dp_if.retire = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; idle_events();
    check_eq("clr_instr", instr_count, 32'd0);
    check_eq("clr_state", {30'd0, state}, 32'd0);

    // Single step: held button gives one advance cycle, 3 edges in
    stepping_flag = 1'b1; tick();
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("stp_idle", {30'd0, state}, 32'd1);
    next_instr = 1'b1;
    adv_n = 0; adv_first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dp_if.advance) begin
        if (adv_n == 0) adv_first = i;
        adv_n++;
      end
    end
    check_eq("stp_adv_count", 32'(adv_n), 32'd1);
    check_eq("stp_adv_edge", 32'(adv_first), 32'd3);
    check_eq("stp_cycles", cycles, 32'd1);

    // Reset in the middle of STEP_ADV aborts to STEP_IDLE with everything zero
    next_instr = 1'b0; tick(); tick(); tick();
    next_instr = 1'b1; dp_if.retire = 1'b1; tick(); tick(); tick();
    check_eq("mid_adv_state", {30'd0, state}, 32'd2);
    next_instr = 1'b0; dp_if.retire = 1'b0; rst = 1'b0;
    tick();
    check_eq("rs_state", {30'd0, state}, 32'd1);
    check_eq("rs_cycles", cycles, 32'd0);
    check_eq("rs_instr", instr_count, 32'd0);
    rst = 1'b1;

    // Finish while stalled in STEP_IDLE is ignored
    dp_if.finish = 1'b1; tick(); dp_if.finish = 1'b0;
    check_eq("fin_ign_state", {30'd0, state}, 32'd1);

    // Saturation: preload cycles near the top, then advance 3 times
    force dut.cycles_r = 32'hFFFF_FFFE;
    #1;
    release dut.cycles_r;
    m_cycles = 64'h0000_0000_FFFF_FFFE;
    stepping_flag = 1'b0; tick();
    tick(); tick(); tick();
    check_eq("sat_cycles", cycles, 32'hFFFF_FFFF);
    check_eq("sat_ovf", {31'd0, overflow}, 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("sat_clr_ovf", {31'd0, overflow}, 32'd0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      rst                = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 19) == 0) stepping_flag = ~stepping_flag;
      if ($urandom_range(0, 7) == 0)  next_instr = ~next_instr;
      clear              = ($urandom_range(0, 49) == 0);
      dp_if.stall        = $urandom_range(0, 1);
      dp_if.retire       = $urandom_range(0, 1);
      dp_if.retire_arith = $urandom_range(0, 1);
      dp_if.retire_mem   = $urandom_range(0, 1);
      dp_if.finish       = ($urandom_range(0, 149) == 0);
      tick();
    end

    // Finish with retire in RUN, then frozen for 50 cycles
    idle_events(); clear = 1'b0; next_instr = 1'b0; stepping_flag = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    dp_if.retire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dp_if.finish = 1'b1;
    tick();
    check_eq("fin_state", {30'd0, state}, 32'd3);
    check_eq("fin_instr", instr_count, 32'd5);
    check_eq("fin_cycles", cycles, 32'd5);
    for (int i = 0; i < 50; i++) begin
      stepping_flag      = $urandom_range(0, 1);
      next_instr         = $urandom_range(0, 1);
      dp_if.stall        = $urandom_range(0, 1);
      dp_if.retire       = $urandom_range(0, 1);
      dp_if.retire_arith = $urandom_range(0, 1);
      dp_if.retire_mem   = $urandom_range(0, 1);
      dp_if.finish       = $urandom_range(0, 1);
      tick();
    end
    check_eq("frz_instr", instr_count, 32'd5);
    check_eq("frz_cycles", cycles, 32'd5);
    check_eq("frz_state", {30'd0, state}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
